// File: rtl/df_deadlock_monitor.sv
// df_deadlock_monitor
//
// Watches a dataflow region for a global stall: every process is idle, blocked
// on an internal channel, or owns a blocked AXI-stream port, and at least one
// AXI-stream port is blocked. Once that holds for THRESH consecutive cycles,
// deadlock is declared and the blocked-port pattern is captured.
//
// Optional feature: define DF_DEADLOCK_STICKY_EN to make the BLK state sticky
// (left only through clear or reset). Undefined (default): BLK falls back to
// MON on the first cycle the stall condition is absent.
//
// Ports
//   clock            clock, rising edge
//   reset            synchronous active-high reset, highest priority
//   clear            synchronous clear of detection state (back to MON)
//   axis_block_sigs  [N_AXIS] per AXI-stream port blocked flag
//   inst_idle_sigs   [N_PROC] per process idle flag
//   inst_block_sigs  [N_PROC] per process internal-channel blocked flag
//   block            deadlock declared (high while in BLK)
//   axis_block_info  [2*N_AXIS] per-port code, 2'b10 = blocked at detection
//   first_axis       lowest blocked port index at detection
//   detect           one-cycle pulse on BLK entry
//   stall_count      [CNT_W] saturating consecutive stall-cycle count

module df_deadlock_monitor #(
  parameter int unsigned          N_PROC        = 8,
  parameter int unsigned          N_AXIS        = 2,
  parameter logic [N_AXIS*8-1:0]  AXIS_PROC_MAP = {8'd7, 8'd0},
  parameter int unsigned          THRESH        = 1,
  parameter int unsigned          CNT_W         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [N_AXIS-1:0]     axis_block_sigs,
  input  logic [N_PROC-1:0]     inst_idle_sigs,
  input  logic [N_PROC-1:0]     inst_block_sigs,
  output logic                  block,
  output logic [2*N_AXIS-1:0]   axis_block_info,
  output logic [3:0]            first_axis,
  output logic                  detect,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [15:0] ThreshM1 = 16'(THRESH - 1);

  typedef enum logic [1:0] {StMon, StStall, StBlk} state_e;

  state_e              state_q;
  logic [15:0]         count_q;
  logic [CNT_W-1:0]    stall_count_q;
  logic [N_AXIS-1:0]   snap_q;
  logic [3:0]          first_q;
  logic                block_q;
  logic                detect_q;

  logic [N_PROC-1:0]   axis_blk;
  logic [N_PROC-1:0]   stop;
  logic                cond;
  logic [3:0]          first_idx;
  logic                go_blk;

  // Fold AXI-stream blocked flags onto their owning processes.
  always_comb begin
    axis_blk = '0;
    for (int k = 0; k < int'(N_AXIS); k++) begin
      for (int p = 0; p < int'(N_PROC); p++) begin
        if (AXIS_PROC_MAP[k*8 +: 8] == 8'(p)) begin
          axis_blk[p] = axis_blk[p] | axis_block_sigs[k];
        end
      end
    end
  end

  assign stop = inst_idle_sigs | inst_block_sigs | axis_blk;
  // All-idle with no blocked port is a normal quiescent state, not a deadlock.
  assign cond = (&stop) & (|axis_blk);

  // Lowest set port index; scanning downward leaves the lowest one last.
  always_comb begin
    first_idx = '0;
    for (int k = int'(N_AXIS) - 1; k >= 0; k--) begin
      if (axis_block_sigs[k]) begin
        first_idx = 4'(k);
      end
    end
  end

  assign go_blk = cond &&
                  (((state_q == StMon) && (THRESH == 1)) ||
                   ((state_q == StStall) && (count_q == ThreshM1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StMon;
      count_q       <= '0;
      stall_count_q <= '0;
      snap_q        <= '0;
      first_q       <= '0;
      block_q       <= 1'b0;
      detect_q      <= 1'b0;
    end else begin
      // Free-running stall counter, independent of clear and FSM state.
      if (!cond) begin
        stall_count_q <= '0;
      end else if (stall_count_q != '1) begin
        stall_count_q <= stall_count_q + 1'b1;
      end

      detect_q <= 1'b0;

      if (clear) begin
        state_q <= StMon;
        count_q <= '0;
        snap_q  <= '0;
        first_q <= '0;
        block_q <= 1'b0;
      end else if (go_blk) begin
        state_q  <= StBlk;
        count_q  <= '0;
        snap_q   <= axis_block_sigs;
        first_q  <= first_idx;
        block_q  <= 1'b1;
        detect_q <= 1'b1;
      end else begin
        case (state_q)
          StMon: begin
            if (cond) begin
              state_q <= StStall;
              count_q <= 16'd1;
            end
          end
          StStall: begin
            if (!cond) begin
              state_q <= StMon;
              count_q <= '0;
            end else begin
              count_q <= count_q + 16'd1;
            end
          end
          StBlk: begin
`ifndef DF_DEADLOCK_STICKY_EN
            if (!cond) begin
              state_q <= StMon;
              count_q <= '0;
              snap_q  <= '0;
              first_q <= '0;
              block_q <= 1'b0;
            end
`endif
          end
          default: begin
            state_q <= StMon;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    axis_block_info = '0;
    for (int k = 0; k < int'(N_AXIS); k++) begin
      axis_block_info[2*k +: 2] = (block_q && snap_q[k]) ? 2'b10 : 2'b00;
    end
  end

  assign block       = block_q;
  assign detect      = detect_q;
  assign first_axis  = first_q;
  assign stall_count = stall_count_q;

endmodule
